// File: rtl/input_request_ctrl.sv
// Purpose: services the CPU input instruction. Stalls the core while a request
// is pending, waits for a fresh press edge on the conditioned active-low button,
// then captures the (extended) switch value and pulses data_valid for one cycle.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   btn_n      conditioned button, active-low, 1 when released
//   switches   user switch value, sampled only on the capture cycle
//   in_req     CPU is executing an input instruction
//   halt       stall request to CPU control (combinational)
//   data_out   captured word, held until the next capture
//   data_valid one-cycle pulse, data_out valid and CPU may advance
//   wait_led   registered "awaiting user input" indicator
module input_request_ctrl #(
  parameter int unsigned SW_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          SIGN_EXT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_n,
  input  logic [SW_WIDTH-1:0]   switches,
  input  logic                  in_req,
  output logic                  halt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  wait_led
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_PRESS = 2'b01,
    DONE       = 2'b10
  } state_t;

  state_t                state;
  logic                  btn_prev;
  logic                  press;
  logic [DATA_WIDTH-1:0] sw_ext;

  // Falling edge of btn_n; a button already low when sampled gives no edge.
  assign press = btn_prev & ~btn_n;

  // Switch value widened (or truncated) to the datapath width.
  generate
    if (SW_WIDTH >= DATA_WIDTH) begin : g_trunc
      assign sw_ext = switches[DATA_WIDTH-1:0];
    end else begin : g_extend
      localparam int unsigned PAD_W = DATA_WIDTH - SW_WIDTH;
      logic pad_bit;
      assign pad_bit = SIGN_EXT ? switches[SW_WIDTH-1] : 1'b0;
      assign sw_ext  = {{PAD_W{pad_bit}}, switches};
    end
  endgenerate

  // Stall while a request is seen in IDLE and for the whole wait; released in DONE.
  assign halt = ((state == IDLE) && in_req) || (state == WAIT_PRESS);

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      btn_prev   <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      wait_led   <= 1'b0;
    end else begin
      btn_prev   <= btn_n;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Presses seen here are dropped; btn_prev still tracks the button.
          if (in_req) begin
            state    <= WAIT_PRESS;
            wait_led <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          // A withdrawn request beats a simultaneous press.
          if (!in_req) begin
            state    <= IDLE;
            wait_led <= 1'b0;
          end else if (press) begin
            state      <= DONE;
            data_out   <= sw_ext;
            data_valid <= 1'b1;
            wait_led   <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          wait_led <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_request_ctrl.sv
// Bench for input_request_ctrl: a zero-extending and a sign-extending instance
// share all inputs; expected captures are queued when a press is driven and
// popped by a monitor whenever data_valid is seen.
module tb_input_request_ctrl;

  localparam int unsigned SW_W = 16;
  localparam int unsigned DW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            btn_n;
  logic            in_req;
  logic [SW_W-1:0] switches;

  logic            halt, data_valid, wait_led;
  logic [DW-1:0]   data_out;
  logic            halt_s, data_valid_s, wait_led_s;
  logic [DW-1:0]   data_out_s;

  int n_cmp     = 0;
  int n_fail    = 0;
  int valid_cnt = 0;

  logic [DW-1:0] exp_z_q[$];
  logic [DW-1:0] exp_s_q[$];
  logic [DW-1:0] exp_z, exp_s;

  always #5 clk = ~clk;

  input_request_ctrl #(.SW_WIDTH(SW_W), .DATA_WIDTH(DW), .SIGN_EXT(1'b0)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .switches(switches), .in_req(in_req),
    .halt(halt), .data_out(data_out), .data_valid(data_valid), .wait_led(wait_led)
  );

  input_request_ctrl #(.SW_WIDTH(SW_W), .DATA_WIDTH(DW), .SIGN_EXT(1'b1)) dut_s (
    .clk(clk), .reset(reset), .btn_n(btn_n), .switches(switches), .in_req(in_req),
    .halt(halt_s), .data_out(data_out_s), .data_valid(data_valid_s), .wait_led(wait_led_s)
  );

  // Scoreboard monitor: every valid pulse must match the oldest queued capture.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      valid_cnt++;
      n_cmp++;
      if (exp_z_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: data_valid=1 data_out=%h, required no pulse", data_out);
      end else begin
        exp_z = exp_z_q.pop_front();
        exp_s = exp_s_q.pop_front();
        if (data_out !== exp_z) begin
          n_fail++;
          $display("FAIL sb_data_zext: got %h, required %h", data_out, exp_z);
        end
        n_cmp++;
        if (data_out_s !== exp_s || data_valid_s !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_data_sext: got %h valid=%b, required %h valid=1",
                   data_out_s, data_valid_s, exp_s);
        end
        n_cmp++;
        if (halt !== 1'b0) begin
          n_fail++;
          $display("FAIL sb_halt_in_valid: got %b, required 0", halt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] ez, input logic [DW-1:0] es);
    exp_z_q.push_back(ez);
    exp_s_q.push_back(es);
  endtask

  // Bounded wait for a valid pulse; returns at the negedge of the valid cycle.
  task automatic wait_valid(input int max_cyc, input string name);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      tick();
      @(negedge clk);
      if (data_valid === 1'b1) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: no data_valid within %0d cycles, required a pulse", name, max_cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_req = 1'b0; btn_n = 1'b1; switches = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (data_out !== '0) begin n_fail++; $display("FAIL rst_data_out: got %h, required 0", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_data_valid: got %b, required 0", data_valid); end
    n_cmp++; if (halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b, required 0", halt); end
    n_cmp++; if (wait_led !== 1'b0) begin n_fail++; $display("FAIL rst_wait_led: got %b, required 0", wait_led); end
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (halt !== 1'b0 || wait_led !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle: halt=%b wait_led=%b, required 0 0", halt, wait_led);
    end
  endtask

  task automatic test_basic();
    int v0 = valid_cnt;
    tick();
    switches = 16'h00A5; in_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (halt !== 1'b1) begin n_fail++; $display("FAIL basic_halt_first: got %b, required 1", halt); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      n_cmp++; if (halt !== 1'b1 || wait_led !== 1'b1) begin
        n_fail++; $display("FAIL basic_waiting c%0d: halt=%b wait_led=%b, required 1 1", i, halt, wait_led);
      end
    end
    tick();
    btn_n = 1'b0;
    push_exp(32'h000000A5, 32'h000000A5);
    wait_valid(4, "basic_valid");
    n_cmp++; if (wait_led !== 1'b0 || halt !== 1'b0) begin
      n_fail++; $display("FAIL basic_valid_cycle: halt=%b wait_led=%b, required 0 0", halt, wait_led);
    end
    in_req = 1'b0;
    tick(); tick();
    btn_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++; if (data_out !== 32'h000000A5) begin n_fail++; $display("FAIL basic_hold: got %h, required 000000a5", data_out); end
    n_cmp++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL basic_one_pulse: got %0d, required %0d", valid_cnt - v0, 1); end
  endtask

  task automatic test_sign_ext();
    tick();
    switches = 16'h8001; in_req = 1'b1;
    tick(); tick();
    btn_n = 1'b0;
    push_exp(32'h00008001, 32'hFFFF8001);
    wait_valid(4, "sext_valid");
    n_cmp++; if (data_out_s !== 32'hFFFF8001) begin n_fail++; $display("FAIL sext_word: got %h, required ffff8001", data_out_s); end
    in_req = 1'b0;
    tick(); tick();
    btn_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_held_button();
    int v0 = valid_cnt;
    btn_n = 1'b0;
    tick(); tick();
    switches = 16'hC3C3; in_req = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    n_cmp++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL held_no_capture: got %0d pulses, required 0", valid_cnt - v0); end
    n_cmp++; if (wait_led !== 1'b1 || halt !== 1'b1) begin
      n_fail++; $display("FAIL held_waiting: halt=%b wait_led=%b, required 1 1", halt, wait_led);
    end
    btn_n = 1'b1;
    tick(); tick();
    btn_n = 1'b0;
    push_exp(32'h0000C3C3, 32'hFFFFC3C3);
    wait_valid(4, "held_second_press");
    in_req = 1'b0;
    tick();
    btn_n = 1'b1;
    tick(); tick();
    n_cmp++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL held_one_pulse: got %0d, required 1", valid_cnt - v0); end
  endtask

  task automatic test_abort();
    int v0 = valid_cnt;
    tick();
    switches = 16'h5555; in_req = 1'b1;
    repeat (3) tick();
    tick();
    in_req = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (halt !== 1'b0 || wait_led !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: halt=%b wait_led=%b, required 0 0", halt, wait_led);
    end
    btn_n = 1'b0;
    repeat (3) tick();
    btn_n = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses, required 0", valid_cnt - v0); end
    n_cmp++; if (data_out !== 32'h0000C3C3 || data_out_s !== 32'hFFFFC3C3) begin
      n_fail++; $display("FAIL abort_data_kept: got %h/%h, required 0000c3c3/ffffc3c3", data_out, data_out_s);
    end
    // Press edge and withdrawal on the same edge: withdrawal wins.
    tick();
    in_req = 1'b1;
    tick(); tick();
    in_req = 1'b0; btn_n = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++; if (halt !== 1'b0 || data_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_vs_press: halt=%b valid=%b, required 0 0", halt, data_valid);
    end
    tick();
    btn_n = 1'b1;
    tick();
    n_cmp++; if (valid_cnt !== v0 || data_out !== 32'h0000C3C3) begin
      n_fail++; $display("FAIL abort_vs_press_data: pulses=%0d data=%h, required 0 0000c3c3", valid_cnt - v0, data_out);
    end
  endtask

  task automatic test_reset_mid();
    int v0 = valid_cnt;
    tick();
    switches = 16'h0F0F; in_req = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_cmp++; if (wait_led !== 1'b1) begin n_fail++; $display("FAIL rmid_in_wait: got %b, required 1", wait_led); end
    tick();
    reset = 1'b1; btn_n = 1'b0;
    #1;
    n_cmp++; if (wait_led !== 1'b0 || data_out !== '0 || data_valid !== 1'b0 || halt !== 1'b1) begin
      n_fail++; $display("FAIL rmid_async: led=%b data=%h valid=%b halt=%b, required 0 0 0 1",
                         wait_led, data_out, data_valid, halt);
    end
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (halt !== 1'b1 || wait_led !== 1'b0) begin
      n_fail++; $display("FAIL rmid_idle: halt=%b wait_led=%b, required 1 0", halt, wait_led);
    end
    repeat (6) tick();
    @(negedge clk);
    n_cmp++; if (valid_cnt !== v0 || wait_led !== 1'b1) begin
      n_fail++; $display("FAIL rmid_no_stale: pulses=%0d wait_led=%b, required 0 1", valid_cnt - v0, wait_led);
    end
    btn_n = 1'b1;
    tick();
    btn_n = 1'b0;
    push_exp(32'h00000F0F, 32'h00000F0F);
    wait_valid(4, "rmid_fresh_press");
    in_req = 1'b0;
    tick();
    btn_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    tick();
    switches = 16'h1357; in_req = 1'b1;
    tick();
    btn_n = 1'b0;
    push_exp(32'h00001357, 32'h00001357);
    tick();
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL min_latency: valid=%b in 3rd cycle, required 1", data_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (halt !== 1'b1 || data_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_new_req: halt=%b valid=%b, required 1 0", halt, data_valid);
    end
    repeat (5) tick();
    n_cmp++; if (valid_cnt !== v0 + 1) begin n_fail++; $display("FAIL b2b_no_repeat: got %0d pulses, required 1", valid_cnt - v0); end
    switches = 16'hFFFF; btn_n = 1'b1;
    tick();
    btn_n = 1'b0;
    push_exp(32'h0000FFFF, 32'hFFFFFFFF);
    wait_valid(4, "b2b_second");
    in_req = 1'b0;
    tick();
    btn_n = 1'b1;
    tick(); tick();
    n_cmp++; if (valid_cnt !== v0 + 2) begin n_fail++; $display("FAIL b2b_two_pulses: got %0d, required 2", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_ext();
    test_held_button();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    n_cmp++; if (exp_z_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drained: %0d captures outstanding, required 0", exp_z_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
